// File: rtl/csi_pkg.sv
// CSI-2 shared definitions: data types, command encodings, FSM states and
// the header ECC used by both the transmit builder and the receive handler.
package csi_pkg;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_RAW8  = 6'h2A;
    localparam logic [5:0] DT_RAW10 = 6'h2B;

    localparam logic [15:0] CRC_POLY = 16'h8408;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        CMD_FS   = 2'd0,
        CMD_FE   = 2'd1,
        CMD_LONG = 2'd2,
        CMD_RSVD = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_PAY,
        ST_CRC
    } state_e;

    // Hamming parity over {WC, DI}; the top two ECC bits are always zero
    function automatic logic [7:0] csi_ecc6(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11]
             ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12]
             ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12]
             ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14]
             ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17]
             ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16]
             ^ d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return {2'b00, p};
    endfunction

endpackage

// File: rtl/csi_crc16.sv
// CSI-2 payload CRC-16 (reflected 0x8408), two bytes per cycle, lane0 first.
module csi_crc16
    import csi_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] data,
    output logic [15:0] crc
);

    logic [15:0] nxt;
    logic        fb;

    always_comb begin
        nxt = crc;
        fb  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            fb  = nxt[0] ^ data[i];
            nxt = {1'b0, nxt[15:1]} ^ (fb ? CRC_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= nxt;
        end
    end

endmodule

// File: rtl/csi_pckt_builder.sv
// CSI-2 transmit packet builder: header, payload and CRC on two byte lanes.
// Define CSI_PCKT_FRAME_CNT_EN to carry a frame counter in FS/FE word count.
module csi_pckt_builder
    import csi_pkg::*;
#(
    parameter int DATA_STREAM_WIDTH = 16,
    parameter int PH_STREAM_WIDTH   = 24
) (
    input  logic                         rxbyteclkhs,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_type,
    input  logic [1:0]                   cmd_vc,
    input  logic [5:0]                   cmd_dt,
    input  logic [15:0]                  cmd_wc,
    input  logic [DATA_STREAM_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_STREAM_WIDTH-1:0] out_stream,
    output logic                         out_valid,
    output logic                         frame_active,
    output logic                         pckt_err
);

    state_e state, state_nxt;

    logic [7:0]  di_r, di_cmd;
    logic [15:0] wc_r, wc_cmd, cnt_r;
    logic        short_r, fs_r, odd_r;
    logic        fa_set, fa_clr;
    logic [15:0] fs_wc, fe_wc;
    logic [DATA_STREAM_WIDTH-1:0] out_nxt;
    logic        vld_nxt, err_nxt, cap, crc_clr, crc_en;
    logic [15:0] crc;
    logic [PH_STREAM_WIDTH-1:0] ph;
    logic [7:0]  ecc;

`ifdef CSI_PCKT_FRAME_CNT_EN
    logic [15:0] frame_cnt, frame_inc;

    // zero is reserved for "no frame number"
    assign frame_inc = (frame_cnt == 16'hFFFF) ? 16'h0001 : frame_cnt + 16'h0001;
    assign fs_wc     = frame_inc;
    assign fe_wc     = frame_cnt;

    always_ff @(posedge rxbyteclkhs) begin
        if (reset) begin
            frame_cnt <= 16'h0000;
        end else if (cap && cmd_type == CMD_FS) begin
            frame_cnt <= frame_inc;
        end
    end
`else
    assign fs_wc = 16'h0000;
    assign fe_wc = 16'h0000;
`endif

    assign ph  = {wc_r, di_r};
    assign ecc = csi_ecc6(ph);

    always_comb begin
        di_cmd = {cmd_vc, cmd_dt};
        wc_cmd = {cmd_wc[15:1], 1'b0};
        unique case (cmd_type)
            CMD_FS: begin
                di_cmd = {cmd_vc, DT_FS};
                wc_cmd = fs_wc;
            end
            CMD_FE: begin
                di_cmd = {cmd_vc, DT_FE};
                wc_cmd = fe_wc;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        out_nxt   = '0;
        vld_nxt   = 1'b0;
        err_nxt   = 1'b0;
        cap       = 1'b0;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_type == CMD_RSVD) begin
                        err_nxt = 1'b1;
                    end else begin
                        cap       = 1'b1;
                        state_nxt = ST_HDR0;
                    end
                end
            end
            ST_HDR0: begin
                vld_nxt   = 1'b1;
                out_nxt   = {wc_r[7:0], di_r};
                err_nxt   = odd_r;
                crc_clr   = 1'b1;
                state_nxt = ST_HDR1;
            end
            ST_HDR1: begin
                vld_nxt = 1'b1;
                out_nxt = {ecc, wc_r[15:8]};
                if (short_r) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_r == 16'h0000) begin
                    state_nxt = ST_CRC;
                end else begin
                    state_nxt = ST_PAY;
                end
            end
            ST_PAY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    vld_nxt = 1'b1;
                    out_nxt = in_data;
                    crc_en  = 1'b1;
                    if (cnt_r == 16'd2) begin
                        state_nxt = ST_CRC;
                    end
                end else begin
                    // starved mid-packet: truncate and end the burst
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_CRC: begin
                vld_nxt   = 1'b1;
                out_nxt   = crc;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge rxbyteclkhs) begin
        if (reset) begin
            state        <= ST_IDLE;
            di_r         <= 8'h00;
            wc_r         <= 16'h0000;
            cnt_r        <= 16'h0000;
            short_r      <= 1'b0;
            fs_r         <= 1'b0;
            odd_r        <= 1'b0;
            fa_set       <= 1'b0;
            fa_clr       <= 1'b0;
            out_stream   <= '0;
            out_valid    <= 1'b0;
            pckt_err     <= 1'b0;
            frame_active <= 1'b0;
        end else begin
            state      <= state_nxt;
            out_stream <= out_nxt;
            out_valid  <= vld_nxt;
            pckt_err   <= err_nxt;
            if (cap) begin
                di_r    <= di_cmd;
                wc_r    <= wc_cmd;
                cnt_r   <= wc_cmd;
                short_r <= (cmd_type != CMD_LONG);
                fs_r    <= (cmd_type == CMD_FS);
                odd_r   <= (cmd_type == CMD_LONG) && cmd_wc[0];
            end else if (crc_en) begin
                cnt_r <= cnt_r - 16'd2;
            end
            // frame_active follows the header word onto the lanes by one cycle
            fa_set       <= (state == ST_HDR1) && short_r && fs_r;
            fa_clr       <= (state == ST_HDR1) && short_r && !fs_r;
            frame_active <= fa_set | (frame_active & ~fa_clr);
        end
    end

    csi_crc16 u_crc (
        .clk   (rxbyteclkhs),
        .reset (reset),
        .clr   (crc_clr),
        .en    (crc_en),
        .data  (in_data),
        .crc   (crc)
    );

endmodule
